// File: rtl/decode_stage.sv
// RV32I decode stage: splits the fetch word into fields, builds the immediate,
// reads rs1/rs2 with write-back bypass and holds the result in a single
// valid/ready output register.

package decode_stage_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011
   } opcode_t;

   // 172-bit decoded instruction handed to execute
   typedef struct packed {
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [6:0]      funct7;
      logic [11:0]     imm;
      logic [XLEN-1:0] imm_extended;
      logic [XLEN-1:0] reg_a;
      logic [XLEN-1:0] reg_b;
      logic [XLEN-1:0] pc;
   } decoded_instr_t;

endpackage

module decode_stage
   import decode_stage_pkg::*;
#(
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_instr,
   input  logic [XLEN-1:0]      in_pc,
   output logic [4:0]           rf_rs1_addr,
   output logic [4:0]           rf_rs2_addr,
   input  logic [XLEN-1:0]      rf_rs1_data,
   input  logic [XLEN-1:0]      rf_rs2_data,
   input  logic                 wb_we,
   input  logic [4:0]           wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output decoded_instr_t       out_instr,
   output logic                 out_illegal
);

   decoded_instr_t dec_c;
   logic           legal_c;
   logic           accept_c;
   logic           stall_c;
   logic           wb_hit_c;

   assign rf_rs1_addr = in_instr[19:15];
   assign rf_rs2_addr = in_instr[24:20];

   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept_c = in_valid && in_ready;
   assign stall_c  = out_valid && !out_ready;
   assign wb_hit_c = BYPASS_EN && wb_we && (wb_rd != 5'd0);

   // Combinational decode of the incoming fetch word
   always_comb begin
      dec_c         = '0;
      legal_c       = 1'b1;
      dec_c.opcode  = in_instr[6:0];
      dec_c.rd      = in_instr[11:7];
      dec_c.funct3  = in_instr[14:12];
      dec_c.rs1     = in_instr[19:15];
      dec_c.rs2     = in_instr[24:20];
      dec_c.funct7  = in_instr[31:25];
      dec_c.pc      = in_pc;

      case (in_instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR: begin
            dec_c.imm          = in_instr[31:20];
            dec_c.imm_extended = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OP_STORE: begin
            dec_c.imm          = {in_instr[31:25], in_instr[11:7]};
            dec_c.imm_extended = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OP_BRANCH: begin
            dec_c.imm          = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
            dec_c.imm_extended = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            dec_c.imm          = in_instr[31:20];
            dec_c.imm_extended = {in_instr[31:12], 12'b0};
         end
         OP_JAL: begin
            dec_c.imm          = in_instr[31:20];
            dec_c.imm_extended = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0};
         end
         OP_REG: begin
            dec_c.imm          = 12'd0;
            dec_c.imm_extended = '0;
         end
         default: begin
            legal_c = 1'b0;
         end
      endcase

      // Operand fetch: x0 reads zero, a same-cycle write-back wins over the file
      if (in_instr[19:15] == 5'd0)
         dec_c.reg_a = '0;
      else if (BYPASS_EN && wb_we && (wb_rd == in_instr[19:15]))
         dec_c.reg_a = wb_data;
      else
         dec_c.reg_a = rf_rs1_data;

      if (in_instr[24:20] == 5'd0)
         dec_c.reg_b = '0;
      else if (BYPASS_EN && wb_we && (wb_rd == in_instr[24:20]))
         dec_c.reg_b = wb_data;
      else
         dec_c.reg_b = rf_rs2_data;
   end

   // Output register: flush > accept > stall refresh > handoff drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_illegal <= 1'b0;
         out_instr   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept_c) begin
         out_valid   <= 1'b1;
         out_instr   <= dec_c;
         out_illegal <= !legal_c;
      end else if (stall_c) begin
         if (wb_hit_c && (wb_rd == out_instr.rs1))
            out_instr.reg_a <= wb_data;
         if (wb_hit_c && (wb_rd == out_instr.rs2))
            out_instr.reg_b <= wb_data;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances (bypass on / off) share the
// stimulus; expected decodes are queued at issue and checked at handoff.

module tb_decode_stage;
   import decode_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] rf_rs1_data;
   logic [31:0] rf_rs2_data;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_ready;

   logic           ir0, ir1, ov0, ov1, il0, il1;
   logic [4:0]     a1_0, a2_0, a1_1, a2_1;
   decoded_instr_t oi0, oi1;

   typedef struct {
      decoded_instr_t i0;
      decoded_instr_t i1;
      logic           ill;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   decode_stage #(.BYPASS_EN(1'b1)) dut_byp (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
      .in_instr(in_instr), .in_pc(in_pc), .rf_rs1_addr(a1_0), .rf_rs2_addr(a2_0),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_we(wb_we),
      .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(ov0),
      .out_ready(out_ready), .out_instr(oi0), .out_illegal(il0)
   );

   decode_stage #(.BYPASS_EN(1'b0)) dut_nob (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
      .in_instr(in_instr), .in_pc(in_pc), .rf_rs1_addr(a1_1), .rf_rs2_addr(a2_1),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .wb_we(wb_we),
      .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(ov1),
      .out_ready(out_ready), .out_instr(oi1), .out_illegal(il1)
   );

   function automatic void chk(input string name, input logic [171:0] act,
                               input logic [171:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic decoded_instr_t mk(
      input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
      input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
      input logic [11:0] imm, input logic [31:0] ext, input logic [31:0] ra,
      input logic [31:0] rb, input logic [31:0] pc);
      decoded_instr_t d;
      d.opcode = op;  d.rd = rd;   d.funct3 = f3; d.rs1 = r1; d.rs2 = r2;
      d.funct7 = f7;  d.imm = imm; d.imm_extended = ext;
      d.reg_a  = ra;  d.reg_b = rb; d.pc = pc;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
      in_valid    = 1'b1;
      in_instr    = instr;
      in_pc       = pc;
      rf_rs1_data = r1;
      rf_rs2_data = r2;
   endtask

   task automatic push(input decoded_instr_t e0, input decoded_instr_t e1,
                       input logic ill);
      exp_t e;
      e.i0 = e0; e.i1 = e1; e.ill = ill;
      q.push_back(e);
   endtask

   // Monitor: compare the head of the queue whenever execute takes an output
   always @(negedge clk) begin
      if (rst_n && ov0 && out_ready && !flush) begin
         if (q.size() == 0) begin
            chk("unexpected_handoff", 172'(oi0.pc), 172'(0));
            checks--;
            if (errors == 0) errors++;
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("handoff_instr_byp", oi0, e.i0);
            chk("handoff_illegal_byp", 172'(il0), 172'(e.ill));
            chk("handoff_valid_nob", 172'(ov1), 172'(1));
            chk("handoff_instr_nob", oi1, e.i1);
            chk("handoff_illegal_nob", 172'(il1), 172'(e.ill));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      decoded_instr_t addi2_pre, addi2_nob, lui_e;

      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      rf_rs1_data = '0; rf_rs2_data = '0; wb_we = 1'b0; wb_rd = '0;
      wb_data = '0; flush = 1'b0; out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #2;
      chk("reset_valid", 172'({ov0, ov1}), 172'(0));
      chk("reset_illegal", 172'({il0, il1}), 172'(0));
      chk("reset_instr_byp", oi0, '0);
      chk("reset_instr_nob", oi1, '0);
      rst_n = 1'b1;
      #1;
      chk("post_reset_in_ready", 172'({ir0, ir1}), 172'(2'b11));
      tick();

      // addi x5,x0,-1
      drive(32'hFFF00293, 32'h100, 32'h11111111, 32'h22222222);
      push(mk(7'h13, 5'd5, 3'd0, 5'd0, 5'd31, 7'h7F, 12'hFFF, 32'hFFFFFFFF,
              32'h0, 32'h22222222, 32'h100),
           mk(7'h13, 5'd5, 3'd0, 5'd0, 5'd31, 7'h7F, 12'hFFF, 32'hFFFFFFFF,
              32'h0, 32'h22222222, 32'h100), 1'b0);
      tick();
      chk("latency1_valid", 172'({ov0, ov1}), 172'(2'b11));

      // beq x1,x2,-8
      drive(32'hFE208CE3, 32'h104, 32'h11111111, 32'h22222222);
      #1;
      chk("rf_addr_beq", 172'({a1_0, a2_0}), 172'({5'd1, 5'd2}));
      push(mk(7'h63, 5'd25, 3'd0, 5'd1, 5'd2, 7'h7F, 12'hFFC, 32'hFFFFFFF8,
              32'h11111111, 32'h22222222, 32'h104),
           mk(7'h63, 5'd25, 3'd0, 5'd1, 5'd2, 7'h7F, 12'hFFC, 32'hFFFFFFF8,
              32'h11111111, 32'h22222222, 32'h104), 1'b0);
      tick();

      // jal x1,-8
      drive(32'hFF9FF0EF, 32'h108, 32'hA1A1A1A1, 32'hB2B2B2B2);
      push(mk(7'h6F, 5'd1, 3'd7, 5'd31, 5'd25, 7'h7F, 12'hFF9, 32'hFFFFFFF8,
              32'hA1A1A1A1, 32'hB2B2B2B2, 32'h108),
           mk(7'h6F, 5'd1, 3'd7, 5'd31, 5'd25, 7'h7F, 12'hFF9, 32'hFFFFFFF8,
              32'hA1A1A1A1, 32'hB2B2B2B2, 32'h108), 1'b0);
      tick();

      // sw x2,-4(x1)
      drive(32'hFE20AE23, 32'h10C, 32'hC3C3C3C3, 32'hD4D4D4D4);
      push(mk(7'h23, 5'd28, 3'd2, 5'd1, 5'd2, 7'h7F, 12'hFFC, 32'hFFFFFFFC,
              32'hC3C3C3C3, 32'hD4D4D4D4, 32'h10C),
           mk(7'h23, 5'd28, 3'd2, 5'd1, 5'd2, 7'h7F, 12'hFFC, 32'hFFFFFFFC,
              32'hC3C3C3C3, 32'hD4D4D4D4, 32'h10C), 1'b0);
      tick();

      // add x6,x5,x5 with a same-cycle write-back to x5
      drive(32'h00528333, 32'h110, 32'h0000AAAA, 32'h0000AAAA);
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
      push(mk(7'h33, 5'd6, 3'd0, 5'd5, 5'd5, 7'h00, 12'h000, 32'h0,
              32'h1234, 32'h1234, 32'h110),
           mk(7'h33, 5'd6, 3'd0, 5'd5, 5'd5, 7'h00, 12'h000, 32'h0,
              32'hAAAA, 32'hAAAA, 32'h110), 1'b0);
      tick();
      wb_we = 1'b0;

      // addi x7,x3,5, then stall it three cycles with a wb to x3 in the last
      drive(32'h00518393, 32'h114, 32'h33333333, 32'h44444444);
      addi2_pre = mk(7'h13, 5'd7, 3'd0, 5'd3, 5'd5, 7'h00, 12'h005, 32'h5,
                     32'h33333333, 32'h44444444, 32'h114);
      addi2_nob = addi2_pre;
      push(mk(7'h13, 5'd7, 3'd0, 5'd3, 5'd5, 7'h00, 12'h005, 32'h5,
              32'h55, 32'h44444444, 32'h114), addi2_nob, 1'b0);
      tick();
      out_ready = 1'b0;
      drive(32'h12345437, 32'h118, 32'h99999999, 32'h99999999);
      #1;
      chk("stall1_in_ready", 172'({ir0, ir1}), 172'(0));
      chk("stall1_instr", oi0, addi2_pre);
      tick();
      chk("stall2_in_ready", 172'({ir0, ir1}), 172'(0));
      chk("stall2_instr", oi0, addi2_pre);
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
      tick();
      chk("stall3_valid", 172'({ov0, ov1}), 172'(2'b11));
      chk("stall_nob_instr", oi1, addi2_nob);

      // Handoff and accept lui x8,0x12345 on the same edge
      wb_we = 1'b0; out_ready = 1'b1;
      drive(32'h12345437, 32'h118, 32'h5555AAAA, 32'h6666BBBB);
      lui_e = mk(7'h37, 5'd8, 3'd5, 5'd8, 5'd3, 7'h09, 12'h123, 32'h12345000,
                 32'h5555AAAA, 32'h6666BBBB, 32'h118);
      tick();
      chk("b2b_valid", 172'({ov0, ov1}), 172'(2'b11));
      chk("b2b_instr", oi0, lui_e);

      // Hold lui, then flush it while a new word is offered
      out_ready = 1'b0; in_valid = 1'b0;
      tick();
      chk("held_valid", 172'(ov0), 172'(1));
      flush = 1'b1;
      drive(32'hFFF00293, 32'h11C, 32'h0, 32'h0);
      #1;
      chk("flush_in_ready", 172'({ir0, ir1}), 172'(0));
      tick();
      chk("flush_valid", 172'({ov0, ov1}), 172'(0));
      chk("flush_keeps_instr", oi0, lui_e);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("post_flush_valid", 172'({ov0, ov1}), 172'(0));
      chk("idle_keeps_instr", oi0, lui_e);

      // Illegal opcode 1111111
      drive(32'h12345FFF, 32'h200, 32'h77777777, 32'h88888888);
      push(mk(7'h7F, 5'd31, 3'd5, 5'd8, 5'd3, 7'h09, 12'h000, 32'h0,
              32'h77777777, 32'h88888888, 32'h200),
           mk(7'h7F, 5'd31, 3'd5, 5'd8, 5'd3, 7'h09, 12'h000, 32'h0,
              32'h77777777, 32'h88888888, 32'h200), 1'b1);
      tick();
      chk("illegal_flag", 172'({il0, il1}), 172'(2'b11));

      // Accept one more, stall it, then reset mid-cycle
      drive(32'hFFF00293, 32'h204, 32'h0, 32'h0);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pre_reset_valid", 172'(ov0), 172'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 172'({ov0, ov1}), 172'(0));
      chk("async_reset_illegal", 172'({il0, il1}), 172'(0));
      chk("async_reset_instr", oi0, '0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("reset_release_in_ready", 172'({ir0, ir1}), 172'(2'b11));
      tick();

      for (int k = 0; k < 20 && q.size() != 0; k++) tick();
      chk("queue_drained", 172'(q.size()), 172'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
